// File: rtl/seg7_scan_driver_if.sv
// Display bus between the top-level selection logic and seg7_scan_driver.
// With SEG7_BRIGHTNESS_EN defined the bus also carries a 4-bit brightness level.
interface seg7_scan_driver_if;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        lz_blank;
  logic        hold;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]  brightness;
`endif
  logic [7:0]  LEDSEL;
  logic [7:0]  LEDOUT;
  logic        frame_start;

`ifdef SEG7_BRIGHTNESS_EN
  modport master (output value, dp_mask, lz_blank, hold, brightness,
                  input  LEDSEL, LEDOUT, frame_start);
  modport slave  (input  value, dp_mask, lz_blank, hold, brightness,
                  output LEDSEL, LEDOUT, frame_start);
`else
  modport master (output value, dp_mask, lz_blank, hold,
                  input  LEDSEL, LEDOUT, frame_start);
  modport slave  (input  value, dp_mask, lz_blank, hold,
                  output LEDSEL, LEDOUT, frame_start);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with frame snapshot,
// leading-zero blanking and anti-ghosting blank. Optional macro: SEG7_BRIGHTNESS_EN.
module seg7_scan_driver #(
  parameter int TICK_DIV     = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int             CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap_val;
  logic [7:0]    snap_dp;
  logic          snap_lz;
  logic          primed;

  logic          slot_end;
  logic          frame_boundary;
  logic          snap_load;
  logic [7:0]    lead_zero;
  logic [3:0]    cur_nib;
  logic          blank_digit;
  logic [6:0]    seg;
  int            cnt_i;
  int            lim;
  logic          drive;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end       = (cnt == CNT_LAST);
  assign frame_boundary = slot_end && (idx == 3'd7);
  assign snap_load      = !bus.hold && (!primed || frame_boundary);
  assign cnt_i          = 32'(cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Snapshot only reloads at frame boundaries, so one frame never mixes two words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_val <= 32'd0;
      snap_dp  <= 8'd0;
      snap_lz  <= 1'b0;
      primed   <= 1'b0;
    end else if (snap_load) begin
      snap_val <= bus.value;
      snap_dp  <= bus.dp_mask;
      snap_lz  <= bus.lz_blank;
      primed   <= 1'b1;
    end
  end

  // lead_zero[k] is set when nibbles 7..k of the snapshot are all zero.
  always_comb begin
    lead_zero    = 8'd0;
    lead_zero[7] = (snap_val[31:28] == 4'd0);
    for (int k = 6; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (snap_val[k*4 +: 4] == 4'd0);
    end
  end

  assign cur_nib     = snap_val[{idx, 2'b00} +: 4];
  assign blank_digit = snap_lz && lead_zero[idx] && (idx != 3'd0);
  assign seg         = blank_digit ? 7'h7F : hex7(cur_nib);

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] bright_q;
  logic [3:0] bright_eff;

  // Level is latched at slot start; the cnt==0 cycle uses the live input directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= 4'hF;
    end else if (cnt == '0) begin
      bright_q <= bus.brightness;
    end
  end

  assign bright_eff = (cnt == '0) ? bus.brightness : bright_q;
  assign lim = BLANK_CYCLES +
               ((int'({28'd0, bright_eff}) + 1) * (TICK_DIV - BLANK_CYCLES)) / 16;
`else
  assign lim = TICK_DIV;
`endif

  assign drive = (cnt_i >= BLANK_CYCLES) && (cnt_i < lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.LEDSEL      <= 8'hFF;
      bus.LEDOUT      <= 8'hFF;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= frame_boundary;
      if (drive) begin
        bus.LEDSEL <= ~(8'd1 << idx);
        bus.LEDOUT <= {~snap_dp[idx], seg};
      end else begin
        bus.LEDSEL <= 8'hFF;
        bus.LEDOUT <= 8'hFF;
      end
    end
  end

endmodule
